// File: rtl/select_arb_pkg.sv
// select_arb_pkg: shared types for the select arbiter (state encoding, select width).
package select_arb_pkg;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/select_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Scans from ptr upward (wrapping
// modulo N) and returns the first valid index as one-hot grant plus binary index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  int          w_j;
  logic [IW-1:0] w_jj;

  // First valid requester at or after the pointer wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    w_jj    = '0;
    for (int i = 0; i < N; i++) begin
      w_j = int'(i_ptr) + i;
      if (w_j >= N) w_j = w_j - N;
      w_jj = IW'(w_j);
      if (!o_any && i_valid[w_jj]) begin
        o_any         = 1'b1;
        o_grant[w_jj] = 1'b1;
        o_idx         = w_jj;
      end
    end
  end
endmodule

// File: rtl/select_arbiter.sv
// select_arbiter: round-robin share of one combinational select->data lookup.
// Each accepted request walks IDLE -> LOOKUP -> RESP; the select is held in a
// register so the lookup input never glitches. Optional per-requester grant
// counters are built when SELECT_ARB_COUNT_EN is defined.
module select_arbiter
  import select_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LANES   = 3,
  parameter int LANE_W  = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][SEL_W-1:0]     req_select,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [SEL_W-1:0]                  lut_select,
  input  logic [LANES-1:0][LANE_W-1:0]      lut_data,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [IW-1:0]                     rsp_id,
  output logic [LANES-1:0][LANE_W-1:0]      rsp_data
`ifdef SELECT_ARB_COUNT_EN
  , output logic [NUM_REQ-1:0][7:0]         grant_cnt
`endif
);
  arb_state_t           r_state;
  sel_t                 r_sel;
  logic [IW-1:0]        r_id;
  logic [IW-1:0]        r_ptr;
  logic [NUM_REQ-1:0]   w_grant;
  logic [IW-1:0]        w_idx;
  logic                 w_any;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Accept only in IDLE; gating with rst_n keeps ready low while reset is held.
  assign req_ready  = (r_state == IDLE && rst_n) ? w_grant : '0;
  assign lut_select = r_sel;

  // Transaction FSM with select/id/response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sel     <= '0;
      r_id      <= '0;
      r_ptr     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_sel   <= req_select[w_idx];
          r_id    <= w_idx;
          r_state <= LOOKUP;
        end
        LOOKUP: begin
          rsp_data  <= lut_data;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          r_ptr     <= (r_id == IW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SELECT_ARB_COUNT_EN
  logic [NUM_REQ-1:0] w_accept;
  assign w_accept = req_ready & req_valid;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    logic [7:0] r_cnt;
    // Saturating count of accepts for requester g.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            r_cnt <= '0;
      else if (w_accept[g] && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end
    assign grant_cnt[g] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_select_arbiter.sv
// tb_select_arbiter: directed stimulus with a response scoreboard. Stimulus pushes
// expected {id,data} into a queue; a negedge monitor pops on every rsp handshake.
module tb_select_arbiter;
  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0][1:0]  req_select;
  logic [3:0]       req_ready;
  logic [1:0]       lut_select;
  logic [2:0][3:0]  lut_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [2:0][3:0]  rsp_data;
`ifdef SELECT_ARB_COUNT_EN
  logic [3:0][7:0]  grant_cnt;
`endif

  typedef struct packed { logic [1:0] id; logic [11:0] data; } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  select_arbiter #(.NUM_REQ(4), .LANES(3), .LANE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_select(req_select),
    .req_ready(req_ready), .lut_select(lut_select), .lut_data(lut_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef SELECT_ARB_COUNT_EN
    , .grant_cnt(grant_cnt)
`endif
  );

  // Team 3-lane case lookup.
  always_comb begin
    case (lut_select)
      2'd0:    lut_data = 12'h73A;
      2'd1:    lut_data = 12'h906;
      2'd2:    lut_data = 12'h8D3;
      default: lut_data = 12'h8D0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: a response is consumed on any negedge with valid&ready.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_rsp: got id %0d data %0h, expected none", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for an accept, check the one-hot grant, return in the next cycle.
  task automatic wait_accept(input logic [3:0] exp_g, input string nm);
    bit hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (|(req_ready & req_valid)) hit = 1;
    end
    if (hit) chk(nm, 32'(req_ready), 32'(exp_g));
    else begin
      n_cmp++; n_err++;
      $display("FAIL %s: no accept within 20 cycles, expected grant %0h", nm, exp_g);
    end
    step();
  endtask

  task automatic pulse_reset();
    req_valid = '0; rsp_ready = 1'b1;
    rst_n = 1'b0; #3; rst_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1 reset with all requests valid
    rst_n = 1'b0; req_valid = 4'hF; rsp_ready = 1'b0;
    req_select = '0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_lut_select", 32'(lut_select), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    req_valid = '0;
    step(); rst_n = 1'b1;
    step();

    // 2 single requester 2, select 1
    req_select[2] = 2'd1; req_valid = 4'b0100; rsp_ready = 1'b1;
    q.push_back('{id: 2'd2, data: 12'h906});
    @(negedge clk);
    chk("single_ready_N", 32'(req_ready), 32'h4);
    step(); req_valid = '0;
    @(negedge clk);
    chk("single_valid_N1", 32'(rsp_valid), 32'h0);
    chk("single_lut_sel", 32'(lut_select), 32'h1);
    step();
    @(negedge clk);
    chk("single_valid_N2", 32'(rsp_valid), 32'h1);
    step();
    @(negedge clk);
    chk("single_lut_hold", 32'(lut_select), 32'h1);

    // 3 round robin from pointer 0
    pulse_reset();
    req_select = {2'd3, 2'd2, 2'd1, 2'd0};
    q.push_back('{id: 2'd0, data: 12'h73A});
    q.push_back('{id: 2'd1, data: 12'h906});
    q.push_back('{id: 2'd2, data: 12'h8D3});
    q.push_back('{id: 2'd3, data: 12'h8D0});
    q.push_back('{id: 2'd0, data: 12'h73A});
    req_valid = 4'hF;
    wait_accept(4'b0001, "rr_g0");
    wait_accept(4'b0010, "rr_g1");
    wait_accept(4'b0100, "rr_g2");
    wait_accept(4'b1000, "rr_g3");
    wait_accept(4'b0001, "rr_g4");
    req_valid = '0;
    repeat (4) step();

    // 4 backpressure: pointer now 1
    rsp_ready = 1'b0; req_valid = 4'b0011;
    q.push_back('{id: 2'd1, data: 12'h906});
    wait_accept(4'b0010, "bp_g1");
    @(negedge clk);
    chk("bp_valid_N1", 32'(rsp_valid), 32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_data", 32'(rsp_data), 32'h906);
      chk("bp_hold_id", 32'(rsp_id), 32'h1);
      chk("bp_ready_low", 32'(req_ready), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    q.push_back('{id: 2'd0, data: 12'h73A});
    wait_accept(4'b0001, "bp_next_g0");
    req_valid = '0;
    repeat (4) step();

    // 5 reset during RESP
    rsp_ready = 1'b0; req_select[3] = 2'd3; req_valid = 4'b1000;
    wait_accept(4'b1000, "mid_g3");
    req_valid = '0;
    step();
    @(negedge clk);
    chk("mid_in_resp", 32'(rsp_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_data", 32'(rsp_data), 32'h0);
    chk("mid_rst_id", 32'(rsp_id), 32'h0);
    step(); rst_n = 1'b1;
    rsp_ready = 1'b1; req_select[0] = 2'd0; req_valid = 4'b1001;
    q.push_back('{id: 2'd0, data: 12'h73A});
    q.push_back('{id: 2'd3, data: 12'h8D0});
    wait_accept(4'b0001, "post_rst_g0");
    req_valid = 4'b1000;
    wait_accept(4'b1000, "post_rst_g3");
    req_valid = '0;
    repeat (4) step();

`ifdef SELECT_ARB_COUNT_EN
    // 6 saturating grant counter
    pulse_reset();
    chk("cnt_rst", 32'(grant_cnt), 32'h0);
    req_select[1] = 2'd1; req_valid = 4'b0010;
    for (int k = 0; k < 300; k++) begin
      q.push_back('{id: 2'd1, data: 12'h906});
      wait_accept(4'b0010, "cnt_g1");
    end
    req_valid = '0;
    repeat (4) step();
    chk("cnt1_sat", 32'(grant_cnt[1]), 32'hFF);
    chk("cnt0", 32'(grant_cnt[0]), 32'h0);
    chk("cnt2", 32'(grant_cnt[2]), 32'h0);
    chk("cnt3", 32'(grant_cnt[3]), 32'h0);
`endif

    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
